// File: rtl/cache_replacement_pkg.sv
// Shared types and helpers for the per-set LRU replacement logic.
// Holds the controller FSM states, rank width and one-hot decode.
package cache_replacement_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int MAX_WAYS = 32;

  function automatic int age_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Index of the set bit; callers guarantee the vector is one-hot.
  function automatic int onehot_to_bin(input logic [MAX_WAYS-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WAYS; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// Combinational rank update for one set: invalidate first, then access.
// A chained same-way request ends with that way at rank 0.
module lru_age_update
  import cache_replacement_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int AW   = 1
) (
  input  logic [WAYS-1:0][AW-1:0] ranks_i,
  input  logic                    acc_en_i,
  input  logic [WAYS-1:0]         acc_way_i,
  input  logic                    inv_en_i,
  input  logic [WAYS-1:0]         inv_way_i,
  output logic [WAYS-1:0][AW-1:0] ranks_o
);

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = AW'(WAYS - 1);

  logic [WAYS-1:0][AW-1:0] mid_ranks;
  logic [AW-1:0]           inv_rank;
  logic [AW-1:0]           acc_rank;
  logic [AW-1:0]           inv_idx;
  logic [AW-1:0]           acc_idx;

  assign inv_idx = AW'(onehot_to_bin(MAX_WAYS'(inv_way_i)));
  assign acc_idx = AW'(onehot_to_bin(MAX_WAYS'(acc_way_i)));

  always_comb begin
    mid_ranks = ranks_i;
    inv_rank  = ranks_i[inv_idx];
    if (inv_en_i) begin
      for (int i = 0; i < WAYS; i++) begin
        if (inv_way_i[i])                mid_ranks[i] = LAST;
        else if (ranks_i[i] > inv_rank)  mid_ranks[i] = ranks_i[i] - ONE;
      end
    end

    ranks_o  = mid_ranks;
    acc_rank = mid_ranks[acc_idx];
    if (acc_en_i) begin
      for (int i = 0; i < WAYS; i++) begin
        if (acc_way_i[i])                ranks_o[i] = '0;
        else if (mid_ranks[i] < acc_rank) ranks_o[i] = mid_ranks[i] + ONE;
      end
    end
  end

endmodule

// File: rtl/lru_replacement_controller.sv
// Per-set LRU rank store with an init sweep, CPU refresh and snoop demotion.
// Presents the one-hot victim way for the CPU index combinationally.
module lru_replacement_controller
  import cache_replacement_pkg::*;
#(
  parameter int INDEX_WIDTH       = 6,
  parameter int SET_ASSOCIATIVITY = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [INDEX_WIDTH-1:0]       cpuIndex,
  input  logic [SET_ASSOCIATIVITY-1:0] cpuHitNumber,
  input  logic                         accessEnable,
  input  logic [INDEX_WIDTH-1:0]       snoopyIndex,
  input  logic [SET_ASSOCIATIVITY-1:0] snoopyCacheNumber,
  input  logic                         invalidateEnable,
  output logic [SET_ASSOCIATIVITY-1:0] cpuCacheNumber,
  output logic                         ready
);

  localparam int NUM_SETS = 1 << INDEX_WIDTH;
  localparam int AW       = age_width(SET_ASSOCIATIVITY);

  typedef logic [SET_ASSOCIATIVITY-1:0][AW-1:0] set_ranks_t;

  set_ranks_t             ranks_q [NUM_SETS];
  set_ranks_t             ranks_d [NUM_SETS];
  state_t                 state_q, state_d;
  logic [INDEX_WIDTH:0]   sweep_q, sweep_d;
  logic                   ready_q, ready_d;

  set_ranks_t init_ranks;
  set_ranks_t snoop_ranks;
  set_ranks_t cpu_base_ranks;
  set_ranks_t cpu_ranks;
  logic       same_set;

  assign same_set = (cpuIndex == snoopyIndex);

  generate
    for (genvar gi = 0; gi < SET_ASSOCIATIVITY; gi++) begin : g_way
      assign init_ranks[gi]     = AW'(SET_ASSOCIATIVITY - 1 - gi);
      assign cpuCacheNumber[gi] = ready_q && (ranks_q[cpuIndex][gi] == AW'(SET_ASSOCIATIVITY - 1));
    end
  endgenerate

  lru_age_update #(.WAYS(SET_ASSOCIATIVITY), .AW(AW)) u_snoop_update (
    .ranks_i   (ranks_q[snoopyIndex]),
    .acc_en_i  (1'b0),
    .acc_way_i ('0),
    .inv_en_i  (invalidateEnable),
    .inv_way_i (snoopyCacheNumber),
    .ranks_o   (snoop_ranks)
  );

  // On a same-set collision the CPU update starts from the post-invalidate ranks.
  assign cpu_base_ranks = same_set ? snoop_ranks : ranks_q[cpuIndex];

  lru_age_update #(.WAYS(SET_ASSOCIATIVITY), .AW(AW)) u_cpu_update (
    .ranks_i   (cpu_base_ranks),
    .acc_en_i  (accessEnable),
    .acc_way_i (cpuHitNumber),
    .inv_en_i  (1'b0),
    .inv_way_i ('0),
    .ranks_o   (cpu_ranks)
  );

  always_comb begin
    ranks_d = ranks_q;
    state_d = state_q;
    sweep_d = sweep_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        ranks_d[sweep_q[INDEX_WIDTH-1:0]] = init_ranks;
        sweep_d = sweep_q + 1'b1;
        if (sweep_d[INDEX_WIDTH]) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: begin
        if (invalidateEnable && !same_set) ranks_d[snoopyIndex] = snoop_ranks;
        if (accessEnable || (invalidateEnable && same_set)) ranks_d[cpuIndex] = cpu_ranks;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
    end
  end

  // Rank storage is initialised by the sweep, not by reset.
  always_ff @(posedge clock) begin
    ranks_q <= ranks_d;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_lru_replacement_controller.sv
// Randomised bench for two controller instances (2-way and 4-way) against
// an MRU-ordered list model of each set.
module tb_lru_replacement_controller;

  localparam int IW    = 6;
  localparam int NSETS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [IW-1:0] c_idx2, s_idx2, c_idx4, s_idx4;
  logic [1:0]    c_hit2, s_num2, vict2;
  logic [3:0]    c_hit4, s_num4, vict4;
  logic          acc2, inv2, acc4, inv4, rdy2, rdy4;

  lru_replacement_controller #(.INDEX_WIDTH(IW), .SET_ASSOCIATIVITY(2)) dut2 (
    .clock(clk), .reset(rst),
    .cpuIndex(c_idx2), .cpuHitNumber(c_hit2), .accessEnable(acc2),
    .snoopyIndex(s_idx2), .snoopyCacheNumber(s_num2), .invalidateEnable(inv2),
    .cpuCacheNumber(vict2), .ready(rdy2)
  );

  lru_replacement_controller #(.INDEX_WIDTH(IW), .SET_ASSOCIATIVITY(4)) dut4 (
    .clock(clk), .reset(rst),
    .cpuIndex(c_idx4), .cpuHitNumber(c_hit4), .accessEnable(acc4),
    .snoopyIndex(s_idx4), .snoopyCacheNumber(s_num4), .invalidateEnable(inv4),
    .cpuCacheNumber(vict4), .ready(rdy4)
  );

  always #5 clk = ~clk;

  // Model: per set, list of ways ordered most-recent first; last entry is the victim.
  int unsigned order [2][NSETS][$];
  int          m_cnt;
  bit          m_ready;

  int req_ci[2], req_cw[2], req_si[2], req_sw[2];
  bit req_a[2], req_i[2];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int ways_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic m_move(input int d, input int s, input int w, input bit to_front);
    for (int k = 0; k < order[d][s].size(); k++) begin
      if (order[d][s][k] == w) begin
        order[d][s].delete(k);
        break;
      end
    end
    if (to_front) order[d][s].push_front(w);
    else          order[d][s].push_back(w);
  endtask

  function automatic logic [31:0] m_victim(input int d, input int s);
    if (!m_ready) return 32'd0;
    return 32'd1 << order[d][s][order[d][s].size()-1];
  endfunction

  task automatic m_init();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < NSETS; s++) begin
        order[d][s].delete();
        for (int w = ways_of(d) - 1; w >= 0; w--) order[d][s].push_back(w);
      end
  endtask

  task automatic clear_reqs();
    for (int d = 0; d < 2; d++) begin
      req_ci[d] = 0; req_cw[d] = 0; req_a[d] = 0;
      req_si[d] = 0; req_sw[d] = 0; req_i[d] = 0;
    end
  endtask

  // One clock cycle: drive, check zero-cycle victim, then advance the model.
  task automatic step();
    c_idx2 = IW'(req_ci[0]); c_hit2 = 2'(1 << req_cw[0]); acc2 = req_a[0];
    s_idx2 = IW'(req_si[0]); s_num2 = 2'(1 << req_sw[0]); inv2 = req_i[0];
    c_idx4 = IW'(req_ci[1]); c_hit4 = 4'(1 << req_cw[1]); acc4 = req_a[1];
    s_idx4 = IW'(req_si[1]); s_num4 = 4'(1 << req_sw[1]); inv4 = req_i[1];
    if (acc2) assert ($onehot(c_hit2));
    if (inv2) assert ($onehot(s_num2));
    if (acc4) assert ($onehot(c_hit4));
    if (inv4) assert ($onehot(s_num4));
    #1;
    check_val("ready2", 32'(rdy2), 32'(m_ready));
    check_val("ready4", 32'(rdy4), 32'(m_ready));
    check_val("victim2", 32'(vict2), m_victim(0, req_ci[0]));
    check_val("victim4", 32'(vict4), m_victim(1, req_ci[1]));
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_ready = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NSETS) begin
        m_ready = 1;
        m_init();
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (req_i[d]) m_move(d, req_si[d], req_sw[d], 1'b0);
        if (req_a[d]) m_move(d, req_ci[d], req_cw[d], 1'b1);
      end
    end
    @(negedge clk);
  endtask

  task automatic probe(input int d, input int idx, input logic [31:0] exp, input string tag);
    if (d == 0) begin
      c_idx2 = IW'(idx); acc2 = 1'b0; inv2 = 1'b0;
    end else begin
      c_idx4 = IW'(idx); acc4 = 1'b0; inv4 = 1'b0;
    end
    #1;
    check_val(tag, (d == 0) ? 32'(vict2) : 32'(vict4), exp);
  endtask

  initial begin
    clear_reqs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_ready = 0;
    m_cnt   = 0;
    step();
    rst = 1'b0;

    for (int c = 0; c < NSETS; c++) step();
    check_val("ready_after_64", 32'(rdy2), 32'd1);
    probe(0, 5, 32'h1, "set5_victim_sa2");

    probe(1, 3, 32'h1, "sa4_set3_initial");
    for (int w = 0; w < 4; w++) begin
      clear_reqs(); req_a[1] = 1; req_ci[1] = 3; req_cw[1] = w;
      step();
    end
    clear_reqs();
    probe(1, 3, 32'h1, "sa4_set3_after_0123");
    req_a[1] = 1; req_ci[1] = 3; req_cw[1] = 0;
    step();
    clear_reqs();
    probe(1, 3, 32'h2, "sa4_set3_after_way0");
    req_i[1] = 1; req_si[1] = 3; req_sw[1] = 2; req_ci[1] = 3;
    step();
    clear_reqs();
    probe(1, 3, 32'h4, "sa4_set3_inv_way2");

    req_a[1] = 1; req_ci[1] = 7; req_cw[1] = 1;
    req_i[1] = 1; req_si[1] = 7; req_sw[1] = 1;
    step();
    clear_reqs();
    probe(1, 7, 32'h1, "sa4_set7_same_way");

    req_a[0] = 1; req_ci[0] = 2; req_cw[0] = 0;
    req_i[0] = 1; req_si[0] = 9; req_sw[0] = 1;
    step();
    clear_reqs();
    probe(0, 2, 32'h2, "sa2_set2_access");
    probe(0, 9, 32'h2, "sa2_set9_invalidate");

    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++) begin
        req_a[d]  = ($urandom_range(0, 2) != 0);
        req_ci[d] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NSETS-1)) : int'($urandom_range(0, 7));
        req_cw[d] = $urandom_range(0, ways_of(d) - 1);
        req_i[d]  = ($urandom_range(0, 2) == 0);
        req_si[d] = ($urandom_range(0, 3) == 0) ? req_ci[d] : int'($urandom_range(0, 7));
        req_sw[d] = $urandom_range(0, ways_of(d) - 1);
      end
      step();
    end

    clear_reqs();
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 20; c++) step();
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < NSETS; c++) begin
      req_a[0] = 1; req_ci[0] = c; req_a[1] = 1; req_ci[1] = c;
      step();
    end
    clear_reqs();
    check_val("ready_after_resweep", 32'(rdy4), 32'd1);
    for (int s = 0; s < NSETS; s++) begin
      probe(0, s, 32'h1, "resweep_sa2");
      probe(1, s, 32'h1, "resweep_sa4");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
